// File: rtl/vlane_pkg.sv
// rtl/vlane_pkg.sv - shared constants and types for the vector-lane normalizer
package vlane_pkg;

   localparam int VLANE_WIDTH     = 32;
   localparam int VLANE_LOG2WIDTH = 5;

   // Shift-count type: wide enough to express 0..VLANE_WIDTH inclusive
   typedef logic [VLANE_LOG2WIDTH:0] vlane_shcnt_t;

endpackage

// File: rtl/vlane_leadcount.sv
// rtl/vlane_leadcount.sv - combinational leading-zero / redundant-sign-bit counter
module vlane_leadcount
   import vlane_pkg::*;
#(
   parameter int WIDTH     = VLANE_WIDTH,
   parameter int LOG2WIDTH = VLANE_LOG2WIDTH
) (
   input  logic [WIDTH-1:0]   opA,
   input  logic               op_signed,
   output logic [LOG2WIDTH:0] count
);

   logic [WIDTH-1:0] w_scan;

   // Signed mode scans for the first bit differing from the sign. The appended
   // 1 caps the count at WIDTH-1 when every bit equals the sign.
   always_comb begin
      w_scan = opA;
      if (op_signed) begin
         w_scan = {opA[WIDTH-2:0] ^ {(WIDTH-1){opA[WIDTH-1]}}, 1'b1};
      end
   end

   // Priority encode from the top; an all-zero scan reports WIDTH
   always_comb begin
      count = (LOG2WIDTH+1)'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (w_scan[i]) begin
            count = (LOG2WIDTH+1)'(WIDTH - 1 - i);
         end
      end
   end

endmodule

// File: rtl/vlane_normalizer.sv
// rtl/vlane_normalizer.sv - two-stage lane normalizer (optional shift clamp: VLANE_NORMALIZER_CLAMP_EN)
module vlane_normalizer
   import vlane_pkg::*;
#(
   parameter int WIDTH         = VLANE_WIDTH,
   parameter int LOG2WIDTH     = VLANE_LOG2WIDTH,
   parameter int REGISTERBREAK = LOG2WIDTH - 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 en,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     opA,
   input  logic                 op_signed,
`ifdef VLANE_NORMALIZER_CLAMP_EN
   input  logic [LOG2WIDTH:0]   sa_max,
`endif
   output logic                 out_valid,
   output logic [WIDTH-1:0]     result,
   output logic [LOG2WIDTH:0]   count
);

   // Count bits below REGISTERBREAK are applied in stage 2, the rest in stage 1
   localparam logic [LOG2WIDTH:0] C_FINE_MASK = (LOG2WIDTH+1)'((1 << REGISTERBREAK) - 1);

   logic [LOG2WIDTH:0] w_nat_cnt;
   logic [LOG2WIDTH:0] w_cnt;
   logic [LOG2WIDTH:0] w_coarse_cnt;
   logic [WIDTH-1:0]   w_s1_data;
   logic [LOG2WIDTH:0] w_fine_cnt;
   logic [WIDTH-1:0]   w_s2_data;

   logic               r_s1_valid;
   logic [WIDTH-1:0]   r_s1_data;
   logic [LOG2WIDTH:0] r_s1_cnt;
   logic               r_s2_valid;
   logic [WIDTH-1:0]   r_s2_data;
   logic [LOG2WIDTH:0] r_s2_cnt;

   vlane_leadcount #(
      .WIDTH     (WIDTH),
      .LOG2WIDTH (LOG2WIDTH)
   ) u_leadcount (
      .opA       (opA),
      .op_signed (op_signed),
      .count     (w_nat_cnt)
   );

   // Choose the shift actually applied; the clamp limits it denormal-style
   always_comb begin
      w_cnt = w_nat_cnt;
`ifdef VLANE_NORMALIZER_CLAMP_EN
      if (sa_max < w_nat_cnt) begin
         w_cnt = sa_max;
      end
`endif
   end

   assign w_coarse_cnt = w_cnt & ~C_FINE_MASK;
   assign w_s1_data    = opA << w_coarse_cnt;

   // Stage 1: coarse shift; data loads regardless of valid to keep enables simple
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_s1_cnt   <= '0;
      end else if (en) begin
         r_s1_valid <= in_valid;
         r_s1_data  <= w_s1_data;
         r_s1_cnt   <= w_cnt;
      end
   end

   assign w_fine_cnt = r_s1_cnt & C_FINE_MASK;
   assign w_s2_data  = r_s1_data << w_fine_cnt;

   // Stage 2: fine shift; count and valid ride along unchanged
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
         r_s2_cnt   <= '0;
      end else if (en) begin
         r_s2_valid <= r_s1_valid;
         r_s2_data  <= w_s2_data;
         r_s2_cnt   <= r_s1_cnt;
      end
   end

   assign out_valid = r_s2_valid;
   assign result    = r_s2_data;
   assign count     = r_s2_cnt;

endmodule

// File: tb/tb_vlane_normalizer.sv
// tb/tb_vlane_normalizer.sv - directed self-checking bench for vlane_normalizer
module tb_vlane_normalizer;
   import vlane_pkg::*;

   logic         clk;
   logic         resetn;
   logic         en;
   logic         in_valid;
   logic [31:0]  opA;
   logic         op_signed;
`ifdef VLANE_NORMALIZER_CLAMP_EN
   vlane_shcnt_t sa_max;
`endif
   logic         out_valid;
   logic [31:0]  result;
   vlane_shcnt_t count;

   int n_vec;
   int n_fail;

   vlane_normalizer dut (
      .clk       (clk),
      .resetn    (resetn),
      .en        (en),
      .in_valid  (in_valid),
      .opA       (opA),
      .op_signed (op_signed),
`ifdef VLANE_NORMALIZER_CLAMP_EN
      .sa_max    (sa_max),
`endif
      .out_valid (out_valid),
      .result    (result),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issue one operand then a bubble; returns out_valid seen after the first edge
   task automatic apply(input logic [31:0] a, input logic s, output logic early_valid);
      @(negedge clk);
      en = 1'b1; in_valid = 1'b1; opA = a; op_signed = s;
      @(posedge clk); #1;
      early_valid = out_valid;
      @(negedge clk);
      in_valid = 1'b0; opA = 32'h0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; en = 1'b1; in_valid = 1'b1; opA = 32'h1; op_signed = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
      n_vec++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset result: got %h want 00000000", result); end
      n_vec++; if (count !== 6'd0) begin n_fail++; $display("FAIL reset count: got %0d want 0", count); end
      @(negedge clk);
      in_valid = 1'b0; resetn = 1'b1;
      @(posedge clk); #1;
      n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post-reset bubble out_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_count_rules();
      logic [31:0]  a_tab [8] = '{32'h0001_0000, 32'h8000_0000, 32'h0000_0003, 32'h1234_5678,
                                  32'hFFFF_0000, 32'h0000_0001, 32'hC000_0000, 32'hFFF1_2345};
      logic         s_tab [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [5:0]   c_tab [8] = '{6'd15, 6'd0, 6'd30, 6'd3, 6'd15, 6'd30, 6'd1, 6'd11};
      logic [31:0]  r_tab [8] = '{32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 32'h91A2_B3C0,
                                  32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 32'h891A_2800};
      logic ev;
      for (int i = 0; i < 8; i++) begin
         apply(a_tab[i], s_tab[i], ev);
         n_vec++; if (ev !== 1'b0) begin n_fail++; $display("FAIL rules[%0d] latency out_valid after 1 edge: got %b want 0", i, ev); end
         n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rules[%0d] out_valid: got %b want 1", i, out_valid); end
         n_vec++; if (count !== c_tab[i]) begin n_fail++; $display("FAIL rules[%0d] count: got %0d want %0d", i, count, c_tab[i]); end
         n_vec++; if (result !== r_tab[i]) begin n_fail++; $display("FAIL rules[%0d] result: got %h want %h", i, result, r_tab[i]); end
      end
   endtask

   task automatic test_zero();
      logic [31:0]  a_tab [3] = '{32'h0, 32'h0, 32'hFFFF_FFFF};
      logic         s_tab [3] = '{1'b0, 1'b1, 1'b1};
      logic [5:0]   c_tab [3] = '{6'd32, 6'd31, 6'd31};
      logic [31:0]  r_tab [3] = '{32'h0, 32'h0, 32'h8000_0000};
      logic ev;
      for (int i = 0; i < 3; i++) begin
         apply(a_tab[i], s_tab[i], ev);
         n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zero[%0d] out_valid: got %b want 1", i, out_valid); end
         n_vec++; if (count !== c_tab[i]) begin n_fail++; $display("FAIL zero[%0d] count: got %0d want %0d", i, count, c_tab[i]); end
         n_vec++; if (result !== r_tab[i]) begin n_fail++; $display("FAIL zero[%0d] result: got %h want %h", i, result, r_tab[i]); end
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      en = 1'b1; in_valid = 1'b1; opA = 32'h1; op_signed = 1'b0;
      @(posedge clk);
      @(negedge clk);
      opA = 32'h2;
      @(posedge clk); #1;
      n_vec++; if (out_valid !== 1'b1 || count !== 6'd31 || result !== 32'h8000_0000) begin
         n_fail++; $display("FAIL b2b first: got v=%b c=%0d r=%h want v=1 c=31 r=80000000", out_valid, count, result);
      end
      @(negedge clk);
      en = 1'b0; in_valid = 1'b0; opA = 32'h0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         n_vec++; if (out_valid !== 1'b1 || count !== 6'd31) begin
            n_fail++; $display("FAIL b2b stall[%0d]: got v=%b c=%0d want v=1 c=31", k, out_valid, count);
         end
      end
      @(negedge clk);
      en = 1'b1; in_valid = 1'b1; opA = 32'h4;
      @(posedge clk); #1;
      n_vec++; if (out_valid !== 1'b1 || count !== 6'd30 || result !== 32'h8000_0000) begin
         n_fail++; $display("FAIL b2b second: got v=%b c=%0d r=%h want v=1 c=30 r=80000000", out_valid, count, result);
      end
      @(negedge clk);
      in_valid = 1'b0; opA = 32'h0;
      @(posedge clk); #1;
      n_vec++; if (out_valid !== 1'b1 || count !== 6'd29 || result !== 32'h8000_0000) begin
         n_fail++; $display("FAIL b2b third: got v=%b c=%0d r=%h want v=1 c=29 r=80000000", out_valid, count, result);
      end
      @(posedge clk); #1;
      n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b drain out_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_reset_midflight();
      @(negedge clk);
      en = 1'b1; in_valid = 1'b1; opA = 32'h10; op_signed = 1'b0;
      @(posedge clk);
      @(negedge clk);
      opA = 32'h20;
      @(posedge clk); #1;
      n_vec++; if (out_valid !== 1'b1 || count !== 6'd27) begin
         n_fail++; $display("FAIL midflight before reset: got v=%b c=%0d want v=1 c=27", out_valid, count);
      end
      #2 resetn = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b0 || result !== 32'h0 || count !== 6'd0) begin
         n_fail++; $display("FAIL midflight async clear: got v=%b c=%0d r=%h want v=0 c=0 r=0", out_valid, count, result);
      end
      @(negedge clk);
      resetn = 1'b1; in_valid = 1'b0; opA = 32'h0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midflight flushed[%0d] out_valid: got %b want 0", k, out_valid); end
      end
      @(negedge clk);
      in_valid = 1'b1; opA = 32'h100;
      @(posedge clk); #1;
      n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midflight early out_valid: got %b want 0", out_valid); end
      @(negedge clk);
      in_valid = 1'b0; opA = 32'h0;
      @(posedge clk); #1;
      n_vec++; if (out_valid !== 1'b1 || count !== 6'd23 || result !== 32'h8000_0000) begin
         n_fail++; $display("FAIL midflight new op: got v=%b c=%0d r=%h want v=1 c=23 r=80000000", out_valid, count, result);
      end
   endtask

`ifdef VLANE_NORMALIZER_CLAMP_EN
   task automatic test_clamp();
      logic ev;
      sa_max = 6'd4;
      apply(32'h1, 1'b0, ev);
      n_vec++; if (count !== 6'd4 || result !== 32'h10) begin
         n_fail++; $display("FAIL clamp sa_max=4: got c=%0d r=%h want c=4 r=00000010", count, result);
      end
      sa_max = 6'd40;
      apply(32'h1, 1'b0, ev);
      n_vec++; if (count !== 6'd31 || result !== 32'h8000_0000) begin
         n_fail++; $display("FAIL clamp sa_max=40: got c=%0d r=%h want c=31 r=80000000", count, result);
      end
      sa_max = 6'd32;
   endtask
`endif

   initial begin
      n_vec = 0;
      n_fail = 0;
`ifdef VLANE_NORMALIZER_CLAMP_EN
      sa_max = 6'd32;
`endif
      test_reset();
      test_count_rules();
      test_zero();
      test_back_to_back();
      test_reset_midflight();
`ifdef VLANE_NORMALIZER_CLAMP_EN
      test_clamp();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/vlane_normalizer.md
Name: vlane_normalizer

Overview:
- Vector-lane normalize unit: counts redundant leading bits of an operand, then left-shifts the operand so its MSB (unsigned) or first non-sign bit (signed) lands in the top position.
- Returns both the normalized value and the shift count applied.
- It is the inverse-direction companion of the lane barrel shifter: it derives the shift amount from the data instead of consuming one.
- Two-stage pipeline (coarse shift, then fine shift), sitting beside the shifter in the lane ALU for FP-emulation and fixed-point renormalization.

Parameters:
- WIDTH, 32, operand width in bits.
- LOG2WIDTH, 5, log2(WIDTH).
- REGISTERBREAK, LOG2WIDTH-2, number of low count bits applied in stage 2; the remaining upper bits are applied in stage 1.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- en  in  1  pipeline advance; 0 holds every stage register.
- in_valid  in  1  operand valid.
- opA  in  WIDTH  operand.
- op_signed  in  1  0: count leading zeros; 1: count redundant sign bits.
- out_valid  out  1  result valid.
- result  out  WIDTH  normalized operand.
- count  out  LOG2WIDTH+1  shift applied (0..WIDTH).

Behaviour:
- Clock and reset:
  - One clock, clk; reset is asynchronous and active-low, named resetn.
  - On reset, all stage registers clear: out_valid=0, result=0, count=0.
- Count rules:
  - Unsigned: count = number of leading zeros of opA; opA=0 gives count=WIDTH.
  - Signed: count = (number of leading bits equal to opA[WIDTH-1]) - 1.
  - Signed opA=0 and opA=all-ones both give count=WIDTH-1.
  - result = opA << count, zero-filled, truncated to WIDTH.
  - opA=0 always gives result=0.
  - Signed all-ones gives result = 1 followed by zeros (0x80000000 at WIDTH=32).
- Stage 1, captured on the en=1 edge:
  - Full count computed combinationally from opA.
  - Register holds: opA shifted left by count with the low REGISTERBREAK bits masked to 0; the full count; in_valid.
- Stage 2, captured on the next en=1 edge:
  - Stage-1 data shifted left by count[REGISTERBREAK-1:0]; count and valid pass through.
  - result, count and out_valid are driven directly from the stage-2 registers.
- Latency and throughput:
  - Latency is 2 en-qualified edges; throughput is one operand per cycle.
  - No combinational path from any input to any output.
- Stall (en=0): all registers hold, including valid bits. An operand is never lost or duplicated across a stall.
- in_valid=0 bubbles propagate as out_valid=0. Data registers still load on en=1 (don't-care contents), so no enable gating on the data path.
- REGISTERBREAK=0 corner: stage 1 applies the full shift and stage 2 is a pass-through register; latency stays 2.
- Reset mid-operation: in-flight operands are discarded; out_valid is 0 from the reset edge until 2 en-edges after the first post-reset in_valid.

Optional Feature:
- Macro: VLANE_NORMALIZER_CLAMP_EN.
- Defined:
  - Adds input sa_max [LOG2WIDTH:0], sampled with opA and pipelined alongside it.
  - Applied shift becomes min(natural count, sa_max); both result and count reflect the clamped value (denormal-style limiting).
- Undefined: sa_max port absent and no clamp logic; behaviour is exactly as above.

Decomposition:
- Shared package vlane_pkg:
  - Constants VLANE_WIDTH and VLANE_LOG2WIDTH.
  - Count-width typedef vlane_shcnt_t (LOG2WIDTH+1 bits).
- One sub-module, vlane_leadcount: combinational, parameterized WIDTH; opA and op_signed in, count out. It is a tree priority encoder, reusable by the divider.
- Stage registers use the common register cell.

Test Plan:
- Unsigned opA=0x00010000, en=1 -> after 2 edges out_valid=1, count=15, result=0x80000000.
- Signed opA=0xFFFF0000 -> count=15, result=0x80000000. Signed opA=0x00000001 -> count=30, result=0x40000000.
- Zero operands:
  - Unsigned opA=0 -> count=32, result=0.
  - Signed opA=0 -> count=31, result=0.
  - Signed opA=0xFFFFFFFF -> count=31, result=0x80000000.
- Back-to-back stream of 0x1, 0x2, 0x4 with en held 0 for 3 cycles after the second -> outputs in order with counts 31, 30, 29 and no duplicates.
- resetn pulsed low with two operands in flight -> out_valid=0, result=0, count=0 immediately (asynchronous); next operand appears 2 edges after issue.
- With VLANE_NORMALIZER_CLAMP_EN: unsigned opA=0x00000001, sa_max=4 -> count=4, result=0x00000010. With sa_max=40 -> count=31, result=0x80000000.
